dram_loader: RTL and testbench

DRAM_LOADER -- requirements
Module: dram_loader

---
 rtl/dram_loader.sv | 157 +++++++++++++++
 tb/tb_dram_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_loader.sv
// Moves words between a valid/ready stream and a single-port DRAM: load (stream->DRAM) or dump (DRAM->stream).
// Latency: load 1 word/cycle, write lands one edge after its handshake; dump 3 cycles/word minimum.
// Backpressure: in_ready only while loading; a dump word holds out_valid/out_data until out_ready.
module dram_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       length,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              write_en_1,
    output logic [ADDR_W-1:0] addr_1,
    output logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_out_1
);
    typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, SEND, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic [15:0] cnt_inc;
    logic        last;
    logic        in_hs;
    logic        out_hs;

    assign cnt_inc = cnt_q + 16'd1;
    assign last    = (cnt_inc == len_q);
    assign in_hs   = (state_q == LOAD) && in_valid;
    assign out_hs  = (state_q == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The command mode is folded into the state choice, so it need not be stored separately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == 16'd0) state_d = DONE;
                    else if (mode)       state_d = RD_ISSUE;
                    else                 state_d = LOAD;
                end
            end
            LOAD:     if (in_hs && last) state_d = DONE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = SEND;
            SEND:     if (out_hs) state_d = last ? DONE : RD_ISSUE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            RD_ISSUE, RD_WAIT: busy = 1'b1;
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        dout_d = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    cnt_d  = '0;
                    if (mode && (length != 16'd0)) addr_d = base_addr;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    we_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(cnt_q);
                    din_d  = in_data;
                    cnt_d  = cnt_inc;
                end
            end
            RD_WAIT: dout_d = data_out_1;
            SEND: begin
                if (out_hs) begin
                    cnt_d = cnt_inc;
                    if (!last) addr_d = base_q + ADDR_W'(cnt_inc);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            dout_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            dout_q <= dout_d;
        end
    end

    assign write_en_1 = we_q;
    assign addr_1     = addr_q;
    assign data_in_1  = din_q;
    assign out_data   = dout_q;

endmodule

// File: tb/tb_dram_loader.sv
// Scoreboard bench for dram_loader: stimulus pushes expected DRAM writes / dump words, a negedge monitor pops and compares.
module tb_dram_loader;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   length = '0;
    logic          busy, done, in_ready, out_valid, write_en_1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] out_data, data_in_1;
    logic [DW-1:0] data_out_1 = '0;
    logic [AW-1:0] addr_1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr_q[$];
    logic [DW-1:0] exp_rd_q[$];
    wr_t           mon_w;
    wr_t           stim_w;
    logic [DW-1:0] mon_d;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rd_hs_cnt = 0;

    // Unwritten DRAM locations read back as addr ^ 0x5A5A.
    logic [DW-1:0] mem [0:65535];
    bit            wr_flag [0:65535];

    dram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .write_en_1 (write_en_1),
        .addr_1     (addr_1),
        .data_in_1  (data_in_1),
        .data_out_1 (data_out_1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en_1) begin
            mem[addr_1]     <= data_in_1;
            wr_flag[addr_1] <= 1'b1;
        end
        data_out_1 <= wr_flag[addr_1] ? mem[addr_1] : (addr_1 ^ 16'h5A5A);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (write_en_1) begin
            if (exp_wr_q.size() == 0) chk("spurious_write", 1, 0);
            else begin
                mon_w = exp_wr_q.pop_front();
                chk("wr_addr", addr_1, mon_w.a);
                chk("wr_data", data_in_1, mon_w.d);
            end
        end
        if (prev_hold && out_valid) chk("out_data_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
            rd_hs_cnt++;
            if (exp_rd_q.size() == 0) chk("spurious_read", 1, 0);
            else begin
                mon_d = exp_rd_q.pop_front();
                chk("rd_data", out_data, mon_d);
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic run_load(input logic [AW-1:0] b, input logic [15:0] n, input logic [DW-1:0] d0);
        wr_t w;
        done_cnt = 0;
        start = 1'b1; mode = 1'b0; base_addr = b; length = n; in_valid = 1'b1; in_data = d0;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            in_data = d0 + DW'(i);
            w.a = b + AW'(i);
            w.d = in_data;
            exp_wr_q.push_back(w);
            samp();
            chk("load_in_ready", in_ready, 1);
            chk("load_busy", busy, 1);
            if (i > 0) chk("load_we_consecutive", write_en_1, 1);
            tick();
        end
        in_valid = 1'b0;
        samp();
        chk("load_done", done, 1);
        chk("load_busy_in_done", busy, 0);
        chk("load_last_we_in_done", write_en_1, 1);
        chk("load_in_ready_in_done", in_ready, 0);
        tick();
        samp();
        chk("load_done_drop", done, 0);
        chk("load_we_drop", write_en_1, 0);
        chk("load_done_pulses", done_cnt, 1);
        chk("load_wr_q_empty", exp_wr_q.size(), 0);
    endtask

    task automatic run_dump(input logic [AW-1:0] b, input logic [15:0] n, input bit toggle, input bit poke);
        int cyc = 0;
        bit seen = 1'b0;
        done_cnt = 0;
        rd_hs_cnt = 0;
        start = 1'b1; mode = 1'b1; base_addr = b; length = n; out_ready = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        samp();
        chk("dump_busy", busy, 1);
        while (!seen && cyc < 200) begin
            if (done) seen = 1'b1;
            else begin
                chk("dump_in_ready", in_ready, 0);
                chk("dump_we", write_en_1, 0);
                tick();
                cyc++;
                if (toggle) out_ready = ~out_ready;
                start = poke && (cyc == 2);
                if (start) begin
                    mode = 1'b0; base_addr = 16'h0300; length = 16'd5;
                end
                samp();
            end
        end
        chk("dump_done_seen", seen, 1);
        if (!toggle) chk("dump_cycles", cyc, 3 * int'(n));
        chk("dump_busy_in_done", busy, 0);
        out_ready = 1'b0;
        start = 1'b0;
        tick();
        samp();
        chk("dump_done_drop", done, 0);
        chk("dump_idle_busy", busy, 0);
        chk("dump_done_pulses", done_cnt, 1);
        chk("dump_handshakes", rd_hs_cnt, n);
        chk("dump_rd_q_empty", exp_rd_q.size(), 0);
    endtask

    task automatic run_zero(input logic m);
        done_cnt = 0;
        start = 1'b1; mode = m; base_addr = 16'h0050; length = 16'd0;
        tick();
        // A start offered in the DONE cycle must not launch a transfer.
        mode = 1'b0; length = 16'd2;
        samp();
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_we", write_en_1, 0);
        chk("zero_out_valid", out_valid, 0);
        chk("zero_in_ready", in_ready, 0);
        tick();
        start = 1'b0;
        samp();
        chk("zero_start_in_done_ignored", busy, 0);
        tick();
        samp();
        chk("zero_still_idle", busy, 0);
        chk("zero_done_pulses", done_cnt, 1);
    endtask

    task automatic chk_outputs_zero();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_we", write_en_1, 0);
        chk("rst_addr", addr_1, 0);
        chk("rst_din", data_in_1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk_outputs_zero();
        tick();
        rst_n = 1'b1;
        tick();

        run_load(16'h0010, 16'd4, 16'h00A1);
        exp_rd_q.push_back(16'h00A1); exp_rd_q.push_back(16'h00A2);
        exp_rd_q.push_back(16'h00A3); exp_rd_q.push_back(16'h00A4);
        run_dump(16'h0010, 16'd4, 1'b0, 1'b0);

        exp_rd_q.push_back(16'h5A7A); exp_rd_q.push_back(16'h5A7B); exp_rd_q.push_back(16'h5A78);
        run_dump(16'h0020, 16'd3, 1'b1, 1'b0);

        run_zero(1'b0);
        run_zero(1'b1);

        run_load(16'hFFFE, 16'd3, 16'h00B1);
        exp_rd_q.push_back(16'h00B2); exp_rd_q.push_back(16'h00B3);
        run_dump(16'hFFFF, 16'd2, 1'b0, 1'b0);

        exp_rd_q.push_back(16'h5A6A); exp_rd_q.push_back(16'h5A6B); exp_rd_q.push_back(16'h5A68);
        run_dump(16'h0030, 16'd3, 1'b0, 1'b1);

        // Load of 5 interrupted by reset after two handshakes (second write allowed to commit).
        done_cnt = 0;
        start = 1'b1; mode = 1'b0; base_addr = 16'h0040; length = 16'd5;
        in_valid = 1'b1; in_data = 16'h00C1;
        tick();
        start = 1'b0;
        stim_w.a = 16'h0040; stim_w.d = 16'h00C1; exp_wr_q.push_back(stim_w);
        tick();
        in_data = 16'h00C2;
        stim_w.a = 16'h0041; stim_w.d = 16'h00C2; exp_wr_q.push_back(stim_w);
        tick();
        in_valid = 1'b0;
        tick();
        samp();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero();
        tick();
        tick();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_wr_q_empty", exp_wr_q.size(), 0);
        rst_n = 1'b1;
        exp_rd_q.push_back(16'h00C1); exp_rd_q.push_back(16'h00C2);
        run_dump(16'h0040, 16'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
